// File: rtl/sr_pulse_driver_if.sv
// Signal bundle between the set/reset request source and the pulse driver.
// The master drives the raw requests and the gate; the slave returns the
// pulses and the Q/Qn flag.
interface sr_pulse_driver_if;
    logic s_in;
    logic r_in;
    logic g;
    logic s_pulse;
    logic r_pulse;
    logic q;
    logic qn;

    modport master (
        output s_in, r_in, g,
        input  s_pulse, r_pulse, q, qn
    );

    modport slave (
        input  s_in, r_in, g,
        output s_pulse, r_pulse, q, qn
    );
endinterface

// File: rtl/sr_pulse_driver.sv
// Clocked replacement for a NOR set/reset latch. Raw set/reset levels are
// synchronized and debounced per channel. Accepted rising edges become
// single-cycle pulses, and a three-state flag FSM drives registered Q/Qn.
// Channel 0 is set, channel 1 is reset.
module sr_pulse_driver #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_pulse_driver_if.slave   bus
);

    typedef enum logic [1:0] {
        RESET_ST = 2'd0,
        SET_ST   = 2'd1,
        FORBID   = 2'd2
    } state_t;

    // Count value at which a differing sample is accepted as the new level.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw_lvl;
    logic [1:0] db_lvl;
    logic [1:0] pulse_lvl;

    assign raw_lvl = {bus.r_in, bus.s_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CNT_WIDTH-1:0]   cnt_reg;
            logic [CNT_WIDTH-1:0]   cnt_next;
            logic                   db_reg;
            logic                   db_next;
            logic                   db_d_reg;
            logic                   pulse_reg;
            logic                   sync_out;

            assign sync_out = sync_reg[SYNC_STAGES-1];

            // Synchronizer chain for the raw asynchronous request.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_lvl[gi]};
                end
            end

            // Debounce: any sample agreeing with the accepted level restarts the count.
            always_comb begin
                cnt_next = '0;
                db_next  = db_reg;
                if (sync_out != db_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        db_next = sync_out;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            // Debounced level, its one-cycle delay and the gated rising-edge pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg   <= '0;
                    db_reg    <= 1'b0;
                    db_d_reg  <= 1'b0;
                    pulse_reg <= 1'b0;
                end else begin
                    cnt_reg   <= cnt_next;
                    db_reg    <= db_next;
                    db_d_reg  <= db_reg;
                    pulse_reg <= db_reg & ~db_d_reg & bus.g;
                end
            end

            assign db_lvl[gi]    = db_reg;
            assign pulse_lvl[gi] = pulse_reg;
        end
    endgenerate

    state_t state_reg;
    state_t state_next;
    logic   q_reg;
    logic   q_next;
    logic   qn_reg;
    logic   qn_next;

    // State register; Q/Qn are flops loaded alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RESET_ST;
            q_reg     <= 1'b0;
            qn_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            qn_reg    <= qn_next;
        end
    end

    // Next state from the debounced (reset, set) pair; gate low holds.
    always_comb begin
        state_next = state_reg;
        if (bus.g) begin
            case (db_lvl)
                2'b01:   state_next = SET_ST;
                2'b10:   state_next = RESET_ST;
                2'b11:   state_next = FORBID;
                default: begin
                    if (state_reg == FORBID) begin
                        state_next = RESET_ST;
                    end
                end
            endcase
        end
    end

    // Output decode of the upcoming state so Q/Qn change on the same edge as the state.
    always_comb begin
        q_next  = 1'b0;
        qn_next = 1'b1;
        case (state_next)
            SET_ST: begin
                q_next  = 1'b1;
                qn_next = 1'b0;
            end
            FORBID: begin
                q_next  = 1'b0;
                qn_next = 1'b0;
            end
            default: begin
                q_next  = 1'b0;
                qn_next = 1'b1;
            end
        endcase
    end

    assign bus.s_pulse = pulse_lvl[0];
    assign bus.r_pulse = pulse_lvl[1];
    assign bus.q       = q_reg;
    assign bus.qn      = qn_reg;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Bench for sr_pulse_driver: two instances (debounce 4 and debounce 1) share
// one stimulus stream and are compared every cycle against a behavioural
// model, with directed latency and flag checks along the way.
module tb_sr_pulse_driver;

    localparam int SYNC = 2;
    localparam int DB_A = 4;
    localparam int DB_B = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic s_in;
    logic r_in;
    logic g;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sr_pulse_driver_if bus_a ();
    sr_pulse_driver_if bus_b ();

    assign bus_a.s_in = s_in;
    assign bus_a.r_in = r_in;
    assign bus_a.g    = g;
    assign bus_b.s_in = s_in;
    assign bus_b.r_in = r_in;
    assign bus_b.g    = g;

    sr_pulse_driver #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB_A), .CNT_WIDTH(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    sr_pulse_driver #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB_B), .CNT_WIDTH(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    logic [3:0] obs [2];
    assign obs[0] = {bus_a.s_pulse, bus_a.r_pulse, bus_a.q, bus_a.qn};
    assign obs[1] = {bus_b.s_pulse, bus_b.r_pulse, bus_b.q, bus_b.qn};

    // Behavioural model: delay line of raw samples, run length of samples
    // disagreeing with the accepted level, and the flag kept as the last
    // non-idle accepted (set, reset) pair.
    logic m_line  [2][2][SYNC];
    logic m_db    [2][2];
    logic m_dbd   [2][2];
    logic m_pulse [2][2];
    int   m_run   [2][2];
    logic m_ls    [2];
    logic m_lr    [2];

    function automatic int db_of(input int i);
        return (i == 0) ? DB_A : DB_B;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < SYNC; k++) m_line[i][c][k] = 1'b0;
                m_db[i][c]    = 1'b0;
                m_dbd[i][c]   = 1'b0;
                m_pulse[i][c] = 1'b0;
                m_run[i][c]   = 0;
            end
            m_ls[i] = 1'b0;
            m_lr[i] = 1'b1;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            logic old_s;
            logic old_r;
            old_s = m_db[i][0];
            old_r = m_db[i][1];
            for (int c = 0; c < 2; c++) begin
                logic raw_v;
                logic seen;
                raw_v = (c == 0) ? s_in : r_in;
                seen  = m_line[i][c][SYNC-1];
                m_pulse[i][c] = m_db[i][c] & ~m_dbd[i][c] & g;
                m_dbd[i][c]   = m_db[i][c];
                if (seen != m_db[i][c]) begin
                    m_run[i][c] = m_run[i][c] + 1;
                    if (m_run[i][c] >= db_of(i)) begin
                        m_db[i][c]  = seen;
                        m_run[i][c] = 0;
                    end
                end else begin
                    m_run[i][c] = 0;
                end
                for (int k = SYNC - 1; k > 0; k--) m_line[i][c][k] = m_line[i][c][k-1];
                m_line[i][c][0] = raw_v;
            end
            if (g) begin
                if (old_s | old_r) begin
                    m_ls[i] = old_s;
                    m_lr[i] = old_r;
                end else if (m_ls[i] & m_lr[i]) begin
                    m_ls[i] = 1'b0;
                    m_lr[i] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [3:0] model_out(input int i);
        return {m_pulse[i][0], m_pulse[i][1], m_ls[i] & ~m_lr[i], m_lr[i] & ~m_ls[i]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic compare_all();
        chk("model_a {sp,rp,q,qn}", 32'(obs[0]), 32'(model_out(0)));
        chk("model_b {sp,rp,q,qn}", 32'(obs[1]), 32'(model_out(1)));
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        compare_all();
    endtask

    // Run n edges, reporting the first edge (1-based, 0 = none) each pulse appeared.
    task automatic run_watch(input int n, output int f_sa, output int f_ra,
                             output int f_sb, output int n_sa);
        f_sa = 0; f_ra = 0; f_sb = 0; n_sa = 0;
        for (int e = 1; e <= n; e++) begin
            tick();
            if (bus_a.s_pulse && f_sa == 0) f_sa = e;
            if (bus_a.r_pulse && f_ra == 0) f_ra = e;
            if (bus_b.s_pulse && f_sb == 0) f_sb = e;
            if (bus_a.s_pulse) n_sa++;
        end
    endtask

    int f_sa, f_ra, f_sb, n_sa, total;

    initial begin
        s_in  = 1'b0;
        r_in  = 1'b0;
        g     = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();

        // Reset, then idle with the gate open.
        for (int k = 0; k < 3; k++) tick();
        rst_n = 1'b1;
        run_watch(20, f_sa, f_ra, f_sb, n_sa);
        $display("step idle: s_pulses=%0d q=%b qn=%b", n_sa, bus_a.q, bus_a.qn);
        chk("idle_s_pulses", 32'(n_sa), 32'd0);
        chk("idle_r_pulse_edge", 32'(f_ra), 32'd0);
        chk("idle_q_qn", 32'({bus_a.q, bus_a.qn}), 32'b01);

        // Set request held: pulse on edge SYNC+DB+1.
        s_in = 1'b1;
        run_watch(10, f_sa, f_ra, f_sb, n_sa);
        $display("step set: first_a=%0d first_b=%0d count_a=%0d", f_sa, f_sb, n_sa);
        chk("set_latency_a", 32'(f_sa), 32'd7);
        chk("set_latency_b", 32'(f_sb), 32'd4);
        chk("set_pulse_count_a", 32'(n_sa), 32'd1);
        chk("set_q_qn", 32'({bus_a.q, bus_a.qn}), 32'b10);
        s_in = 1'b0;
        run_watch(10, f_sa, f_ra, f_sb, n_sa);
        $display("step set_release: q=%b qn=%b", bus_a.q, bus_a.qn);
        chk("set_release_hold", 32'({bus_a.q, bus_a.qn}), 32'b10);
        chk("set_release_no_pulse", 32'(n_sa), 32'd0);

        // Reset request held.
        r_in = 1'b1;
        run_watch(10, f_sa, f_ra, f_sb, n_sa);
        $display("step reset: first_r_a=%0d q=%b qn=%b", f_ra, bus_a.q, bus_a.qn);
        chk("reset_latency_a", 32'(f_ra), 32'd7);
        chk("reset_q_qn", 32'({bus_a.q, bus_a.qn}), 32'b01);
        r_in = 1'b0;
        run_watch(10, f_sa, f_ra, f_sb, n_sa);

        // Glitch: 3 high, 1 low, 3 high never reaches 4 agreeing samples.
        total = 0;
        s_in = 1'b1; run_watch(3, f_sa, f_ra, f_sb, n_sa); total += n_sa;
        s_in = 1'b0; run_watch(1, f_sa, f_ra, f_sb, n_sa); total += n_sa;
        s_in = 1'b1; run_watch(3, f_sa, f_ra, f_sb, n_sa); total += n_sa;
        s_in = 1'b0; run_watch(10, f_sa, f_ra, f_sb, n_sa); total += n_sa;
        $display("step glitch: s_pulses_a=%0d q=%b", total, bus_a.q);
        chk("glitch_pulses_a", 32'(total), 32'd0);
        chk("glitch_q_qn", 32'({bus_a.q, bus_a.qn}), 32'b01);

        // Simultaneous set and reset, then release both.
        s_in = 1'b1; r_in = 1'b1;
        run_watch(10, f_sa, f_ra, f_sb, n_sa);
        $display("step both: first_s=%0d first_r=%0d q=%b qn=%b", f_sa, f_ra, bus_a.q, bus_a.qn);
        chk("both_s_edge", 32'(f_sa), 32'd7);
        chk("both_r_edge", 32'(f_ra), 32'd7);
        chk("forbid_q_qn", 32'({bus_a.q, bus_a.qn}), 32'b00);
        s_in = 1'b0; r_in = 1'b0;
        run_watch(10, f_sa, f_ra, f_sb, n_sa);
        $display("step both_release: q=%b qn=%b", bus_a.q, bus_a.qn);
        chk("forbid_release_both", 32'({bus_a.q, bus_a.qn}), 32'b01);

        // Simultaneous again, releasing only reset.
        s_in = 1'b1; r_in = 1'b1;
        run_watch(10, f_sa, f_ra, f_sb, n_sa);
        r_in = 1'b0;
        run_watch(10, f_sa, f_ra, f_sb, n_sa);
        $display("step release_r_only: q=%b qn=%b", bus_a.q, bus_a.qn);
        chk("forbid_release_r", 32'({bus_a.q, bus_a.qn}), 32'b10);
        s_in = 1'b0;
        run_watch(10, f_sa, f_ra, f_sb, n_sa);

        // Clear the flag, then hold set with the gate closed.
        r_in = 1'b1; run_watch(10, f_sa, f_ra, f_sb, n_sa);
        r_in = 1'b0; run_watch(10, f_sa, f_ra, f_sb, n_sa);
        g = 1'b0;
        s_in = 1'b1;
        run_watch(10, f_sa, f_ra, f_sb, n_sa);
        $display("step gate_low: s_pulses=%0d q=%b", n_sa, bus_a.q);
        chk("gate_low_pulses", 32'(n_sa), 32'd0);
        chk("gate_low_q_qn", 32'({bus_a.q, bus_a.qn}), 32'b01);
        g = 1'b1;
        tick();
        $display("step gate_rise: q=%b s_pulse=%b", bus_a.q, bus_a.s_pulse);
        chk("gate_rise_q_qn", 32'({bus_a.q, bus_a.qn}), 32'b10);
        chk("gate_rise_no_pulse", 32'(bus_a.s_pulse), 32'd0);
        run_watch(5, f_sa, f_ra, f_sb, n_sa);
        chk("gate_rise_later_pulses", 32'(n_sa), 32'd0);

        // Asynchronous reset while the set count is at 2 and Q=1.
        s_in = 1'b0; run_watch(10, f_sa, f_ra, f_sb, n_sa);
        s_in = 1'b1; run_watch(4, f_sa, f_ra, f_sb, n_sa);
        chk("pre_reset_q", 32'(bus_a.q), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        $display("step async_reset: q=%b qn=%b", bus_a.q, bus_a.qn);
        chk("async_reset_q_qn", 32'({bus_a.q, bus_a.qn}), 32'b01);
        tick();
        tick();
        rst_n = 1'b1;
        run_watch(10, f_sa, f_ra, f_sb, n_sa);
        $display("step reset_restart: first_a=%0d first_b=%0d", f_sa, f_sb);
        chk("restart_latency_a", 32'(f_sa), 32'd7);
        chk("restart_latency_b", 32'(f_sb), 32'd4);
        s_in = 1'b0;
        run_watch(10, f_sa, f_ra, f_sb, n_sa);

        // Random held levels with occasional asynchronous resets.
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            s_in = 1'($urandom_range(0, 1));
            r_in = 1'($urandom_range(0, 1));
            g    = ($urandom_range(0, 9) != 0);
            len  = $urandom_range(1, 12);
            $display("seg %0d: s=%b r=%b g=%b len=%0d", seg, s_in, r_in, g, len);
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                tick();
                rst_n = 1'b1;
            end
            for (int k = 0; k < len; k++) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
